// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared state encoding and default constants for the gate sweep checker
package gate_sweep_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam int SETTLE_DEF = 1;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear
module sat_cnt
  import gate_sweep_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  // Clear wins over increment; the count sticks at all-ones
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive truth-table sweep of a combinational gate against a golden model; GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  vec_o,
  input  logic [OUT_W-1:0] dut_y_i,
  input  logic [OUT_W-1:0] exp_y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [IN_W-1:0]  fail_vec,
  output logic [OUT_W-1:0] fail_y
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  state_t r_state, w_nxt;
  logic [IN_W:0] r_vec;
  logic [SW-1:0] r_set;
  logic r_busy, r_done, r_pass, r_fv;
  logic [IN_W-1:0] r_fvec;
  logic [OUT_W-1:0] r_fy;
  logic w_acc, w_mis, w_inc, w_last, w_stop;
  assign w_acc  = r_state == IDLE && start;
  assign w_mis  = dut_y_i !== exp_y_i;
  assign w_inc  = r_state == CHECK && w_mis;
  assign w_last = r_vec == {1'b0, {IN_W{1'b1}}};
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign w_stop = w_last || w_mis;
`else
  assign w_stop = w_last;
`endif
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_nxt;
  // Next-state: hold each vector SETTLE cycles, check once, then advance or finish
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    w_nxt = start ? APPLY : IDLE;
      APPLY:   w_nxt = (r_set == SW'(SETTLE - 1)) ? CHECK : APPLY;
      CHECK:   w_nxt = w_stop ? DONE : APPLY;
      default: w_nxt = IDLE;
    endcase
  end
  // Settle counter restarts on every entry to APPLY
  always_ff @(posedge clk or posedge rst)
    if (rst) r_set <= '0;
    else r_set <= (r_state == APPLY && w_nxt == APPLY) ? r_set + 1'b1 : '0;
  // Vector counter carries an extra bit so the last vector never aliases to 0
  always_ff @(posedge clk or posedge rst)
    if (rst) r_vec <= '0;
    else if (w_acc || r_state == DONE) r_vec <= '0;
    else if (r_state == CHECK && !w_stop) r_vec <= r_vec + 1'b1;
  // Status flags derive from the next state so they line up with it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_nxt == APPLY || w_nxt == CHECK;
      r_done <= w_nxt == DONE;
    end
  // Verdict folds in a mismatch counted on the same edge that enters DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pass <= 1'b0;
    else if (w_acc) r_pass <= 1'b0;
    else if (r_state == CHECK && w_nxt == DONE) r_pass <= err_cnt == '0 && !w_inc;
  // Keep only the first failing vector of the sweep
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fv   <= 1'b0;
      r_fvec <= '0;
      r_fy   <= '0;
    end else if (w_acc) begin
      r_fv   <= 1'b0;
      r_fvec <= '0;
      r_fy   <= '0;
    end else if (w_inc && !r_fv) begin
      r_fv   <= 1'b1;
      r_fvec <= r_vec[IN_W-1:0];
      r_fy   <= dut_y_i;
    end
  sat_cnt #(.W(CNT_W)) u_err (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_acc),
    .i_inc (w_inc),
    .o_cnt (err_cnt)
  );
  assign vec_o      = r_vec[IN_W-1:0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_valid = r_fv;
  assign fail_vec   = r_fvec;
  assign fail_y     = r_fy;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed sweeps on three checker configurations with a result scoreboard
module tb_gate_sweep_checker;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic       fv;
    logic [3:0] fvec;
    logic       fy0;
    logic [7:0] busy;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic [1:0] vec_a, fvec_a, vec_c, fvec_c;
  logic [3:0] vec_b, fvec_b;
  logic dut_a, exp_a, fy_a, dut_c, exp_c, fy_c;
  logic [1:0] dut_b, exp_b, fy_b, err_b;
  logic [7:0] err_a, err_c;
  logic busy_a, done_a, pass_a, fv_a;
  logic busy_b, done_b, pass_b, fv_b;
  logic busy_c, done_c, pass_c, fv_c;
  logic a_d1 = 1'b1, a_d2 = 1'b1, c_d1 = 1'b1, c_d2 = 1'b1;
  int n_assert = 0, n_fail = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    a_d1 <= ~&vec_a;
    a_d2 <= a_d1;
    c_d1 <= ~&vec_c;
    c_d2 <= c_d1;
  end
  assign exp_a = ~&vec_a;
  assign dut_a = mode_a == 2'd0 ? ~&vec_a : mode_a == 2'd1 ? 1'b1 : mode_a == 2'd2 ? 1'b0 : a_d2;
  assign dut_b = {1'bx, vec_b[0]};
  assign exp_b = {1'b0, ~vec_b[0]};
  assign exp_c = ~&vec_c;
  assign dut_c = c_d2;
  gate_sweep_checker #(.IN_W(2), .OUT_W(1), .SETTLE(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_o(vec_a), .dut_y_i(dut_a), .exp_y_i(exp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_valid(fv_a),
    .fail_vec(fvec_a), .fail_y(fy_a));
  gate_sweep_checker #(.IN_W(4), .OUT_W(2), .SETTLE(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_o(vec_b), .dut_y_i(dut_b), .exp_y_i(exp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_valid(fv_b),
    .fail_vec(fvec_b), .fail_y(fy_b));
  gate_sweep_checker #(.IN_W(2), .OUT_W(1), .SETTLE(3), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .vec_o(vec_c), .dut_y_i(dut_c), .exp_y_i(exp_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c), .fail_valid(fv_c),
    .fail_vec(fvec_c), .fail_y(fy_c));
  function automatic exp_t mk(logic p, logic [7:0] e, logic f, logic [3:0] v, logic y, logic [7:0] b);
    return {p, e, f, v, y, b};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic drive(input int sel, input logic v);
    case (sel)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask
  task automatic sample(input int sel, output logic b, output logic d, output logic p, output logic fv,
                        output logic fy0, output logic [7:0] err, output logic [3:0] vec, output logic [3:0] fvec);
    case (sel)
      0: begin b = busy_a; d = done_a; p = pass_a; fv = fv_a; fy0 = fy_a; err = err_a; vec = {2'b0, vec_a}; fvec = {2'b0, fvec_a}; end
      1: begin b = busy_b; d = done_b; p = pass_b; fv = fv_b; fy0 = fy_b[0]; err = {6'b0, err_b}; vec = vec_b; fvec = fvec_b; end
      default: begin b = busy_c; d = done_c; p = pass_c; fv = fv_c; fy0 = fy_c; err = err_c; vec = {2'b0, vec_c}; fvec = {2'b0, fvec_c}; end
    endcase
  endtask
  task automatic run(input string tag, input int sel, input int per, input int poke, input exp_t e);
    logic b, d, p, fv, fy0;
    logic [7:0] err;
    logic [3:0] vec, fvec;
    int nb;
    bit seen;
    exp_t x;
    q.push_back(e);
    @(negedge clk);
    drive(sel, 1'b1);
    @(negedge clk);
    drive(sel, 1'b0);
    nb = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      sample(sel, b, d, p, fv, fy0, err, vec, fvec);
      if (d) seen = 1'b1;
      else begin
        if (b) begin
          chk({tag, "_vec"}, {28'b0, vec}, nb / per);
          nb++;
        end
        drive(sel, poke != 0 && nb == poke);
        @(negedge clk);
      end
    end
    drive(sel, 1'b0);
    chk({tag, "_done_seen"}, {31'b0, seen}, 1);
    x = q.pop_front();
    chk({tag, "_busy_cycles"}, nb, {24'b0, x.busy});
    chk({tag, "_busy_at_done"}, {31'b0, b}, 0);
    chk({tag, "_pass"}, {31'b0, p}, {31'b0, x.pass});
    chk({tag, "_err_cnt"}, {24'b0, err}, {24'b0, x.err});
    chk({tag, "_fail_valid"}, {31'b0, fv}, {31'b0, x.fv});
    chk({tag, "_fail_vec"}, {28'b0, fvec}, {28'b0, x.fvec});
    chk({tag, "_fail_y"}, {31'b0, fy0}, {31'b0, x.fy0});
    @(negedge clk);
    sample(sel, b, d, p, fv, fy0, err, vec, fvec);
    chk({tag, "_done_pulse"}, {31'b0, d}, 0);
    chk({tag, "_idle_vec"}, {28'b0, vec}, 0);
    chk({tag, "_pass_held"}, {31'b0, p}, {31'b0, x.pass});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy_a}, 0);
    chk("rst_done", {31'b0, done_a}, 0);
    chk("rst_pass", {31'b0, pass_a}, 0);
    chk("rst_err", {24'b0, err_a}, 0);
    chk("rst_fail_valid", {31'b0, fv_a}, 0);
    chk("rst_vec", {30'b0, vec_a}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mode_a = 2'd0;
    run("nand_pass", 0, 2, 0, mk(1'b1, 8'd0, 1'b0, 4'd0, 1'b0, 8'd8));
    run("ignored_start", 0, 2, 3, mk(1'b1, 8'd0, 1'b0, 4'd0, 1'b0, 8'd8));
    mode_a = 2'd1;
    run("stuck1", 0, 2, 0, mk(1'b0, 8'd1, 1'b1, 4'd3, 1'b1, 8'd8));
    mode_a = 2'd2;
    run("stuck0", 0, 2, 0, STOP ? mk(1'b0, 8'd1, 1'b1, 4'd0, 1'b0, 8'd2) : mk(1'b0, 8'd3, 1'b1, 4'd0, 1'b0, 8'd8));
    run("sat_x", 1, 2, 0, STOP ? mk(1'b0, 8'd1, 1'b1, 4'd0, 1'b0, 8'd2) : mk(1'b0, 8'd3, 1'b1, 4'd0, 1'b0, 8'd32));
    mode_a = 2'd3;
    run("delay_settle1", 0, 2, 0, mk(1'b0, 8'd1, 1'b1, 4'd3, 1'b1, 8'd8));
    run("delay_settle3", 2, 4, 0, mk(1'b1, 8'd0, 1'b0, 4'd0, 1'b0, 8'd16));
    mode_a = 2'd2;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", {31'b0, busy_a}, 1);
    chk("mid_err_nonzero", {31'b0, err_a != 8'd0}, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy_a}, 0);
    chk("arst_err", {24'b0, err_a}, 0);
    chk("arst_fail_valid", {31'b0, fv_a}, 0);
    chk("arst_vec", {30'b0, vec_a}, 0);
    chk("arst_pass", {31'b0, pass_a}, 0);
    chk("arst_done", {31'b0, done_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    mode_a = 2'd0;
    run("after_rst", 0, 2, 0, mk(1'b1, 8'd0, 1'b0, 4'd0, 1'b0, 8'd8));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

- Synthesizable, parametrised exhaustive truth-table checker for N-input, M-output combinational gates in the gate library.
- On `start`, drives every input vector from 0 to 2^IN_W−1 onto the device under test and waits a programmable settle time after each.
- Compares the DUT output against a golden-model output, counts mismatches and captures the first failing vector.
- Sits beside a gate instance in a self-test wrapper; replaces hand-written per-gate stimulus with a reusable engine.

## Interface
- `IN_W`, default 2: DUT input width; sweep covers 2^IN_W vectors; legal range 1..16.
- `OUT_W`, default 1: DUT output width.
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range ≥1.
- `CNT_W`, default 8: error-counter width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin sweep; sampled only in IDLE.
- `vec_o` out IN_W: input vector driven to DUT and golden model.
- `dut_y_i` in OUT_W: DUT output.
- `exp_y_i` in OUT_W: golden-model output for `vec_o`.
- `busy` out 1: sweep in progress.
- `done` out 1: single-cycle pulse at sweep end.
- `pass` out 1: last completed sweep had zero mismatches.
- `err_cnt` out CNT_W: mismatch count, saturating at 2^CNT_W−1.
- `fail_valid` out 1: `fail_vec`/`fail_y` hold a captured failure.
- `fail_vec` out IN_W: first failing vector.
- `fail_y` out OUT_W: DUT output observed at first failure.

## Operation
- **Reset values:** state IDLE; all outputs 0, including `pass`.
- **IDLE:**
  - `vec_o`=0.
  - `start`=1 → clear `err_cnt`, `fail_*`, `pass`; vector counter=0; go to APPLY.
- **APPLY:**
  - `vec_o`=current vector, `busy`=1.
  - Settle counter runs for `SETTLE` cycles, then go to CHECK.
- **CHECK:** one cycle.
  - Mismatch is `dut_y_i !== exp_y_i`; any X/Z on either input counts as a mismatch.
  - On mismatch, `err_cnt` increments, saturating.
  - On the first mismatch of the sweep, latch `fail_vec`/`fail_y` and set `fail_valid`.
  - If the vector is all-ones, go to DONE; otherwise increment the vector and go to APPLY.
- **DONE:** one cycle.
  - `done`=1, `busy`=0.
  - `pass` is set to (`err_cnt`==0, including any CHECK update in the same edge); go to IDLE.
- **Held results:** `pass`, `err_cnt` and `fail_*` hold until the next accepted `start`.
- **Vector counter:** IN_W+1 bits, so the all-ones vector is detected without wrapping to 0.
- **Ignored start:** `start` in APPLY/CHECK/DONE is ignored; no restart, no queueing.
- **Reset mid-sweep:** immediate return to reset values; the partial result is discarded.

## Timing
- **start to first drive:** `start` seen at edge k; `vec_o`=0, `busy`=1 from edge k.
- **Per-vector cost:** SETTLE+1 cycles; DUT output is sampled SETTLE cycles after the vector changes.
- **Sweep length:** `busy` high for 2^IN_W·(SETTLE+1) cycles, followed by one `done` cycle.
- **Back-to-back sweeps:** earliest re-`start` is the cycle after `done`.
- **Output registering:** all outputs are registered; no combinational path from `dut_y_i` to any output.

## Configuration
- **Macro:** `GATE_SWEEP_STOP_ON_FAIL_EN`.
- **Defined:** the first mismatch transitions CHECK → DONE directly.
  - Remaining vectors are skipped.
  - `err_cnt`=1, `pass`=0.
- **Undefined:** the full sweep always runs and every mismatch is counted.

## Structure
- **Package `gate_sweep_pkg`:**
  - State enum typedef {IDLE, APPLY, CHECK, DONE}.
  - Default constants for SETTLE and CNT_W.
- **Sub-module `sat_cnt`:** parametrised saturating counter with clear and increment, used for `err_cnt`. It is the natural candidate for reuse in other self-test blocks.

## Test plan
- **NAND pass:** IN_W=2, OUT_W=1, SETTLE=1, `exp_y_i`=~&`vec_o`, correct NAND DUT → `vec_o` steps 0,1,2,3; `busy` high 8 cycles; `done` pulse; `pass`=1, `err_cnt`=0, `fail_valid`=0.
- **Stuck-at-1 DUT:** same setup, DUT output forced to 1 → `err_cnt`=1, `fail_vec`=2'b11, `fail_y`=1, `pass`=0.
  - With `GATE_SWEEP_STOP_ON_FAIL_EN`: same values, and `done` arrives at the same cycle, since the failing vector is the last.
- **Early stop:** DUT forced to 0 with `GATE_SWEEP_STOP_ON_FAIL_EN` → `done` 2 cycles after start, `fail_vec`=0, `err_cnt`=1.
  - Without the macro: `err_cnt`=3, `fail_vec`=0.
- **Saturation and X handling:** IN_W=4, CNT_W=2, DUT output X → `err_cnt` saturates at 3; `fail_valid`=1; `fail_vec`=0.
- **Ignored start and reset mid-sweep:**
  - Pulse `start` during APPLY → no effect on the sweep length.
  - Assert `rst` mid-sweep → all outputs 0 asynchronously; a later `start` runs a full clean sweep with `pass`=1.
- **Settle timing:** SETTLE=3 with a DUT having a 2-cycle registered delay → `pass`=1 and 16 busy cycles.
  - SETTLE=1 with the same DUT → mismatches reported.
